// File: rtl/time_edit_ctrl.sv
// -----------------------------------------------------------------------------
// time_edit_ctrl
//
// Sequences the hour-number display and the time-setting flow.
//   IDLE   : live RTC time (BCD hh/mm/ss) is registered onto the display bus.
//   LOAD   : one-cycle snapshot of the RTC time into the edit registers, with
//            illegal fields replaced by 00.
//   EDIT   : cursor steps across hh/mm/ss, up/down apply BCD edits with wrap.
//            A quiet period of TIMEOUT_CYCLES abandons the edit without writing.
//   COMMIT : wr_req held high with the edited time on the bus until wr_ack.
//
// Handshake: wr_req rises on entry to COMMIT and stays high, with hour_out1..3
// frozen, until a cycle in which wr_ack=1 is sampled; wr_req drops on the next
// edge. wr_ack is ignored in every other state.
//
// Ports
//   clk                        system clock
//   reset                      asynchronous, active-low
//   btn_prog/up/down/left/right single-cycle button pulses
//   rtc_hour/min/sec [7:0]     live BCD time {tens,units}
//   wr_ack                     RTC accepted the write (pulse)
//   hour_out1/2/3    [7:0]     BCD hh/mm/ss to the renderer
//   programar_on               high in EDIT and COMMIT
//   direccion_actual_pantalla  cursor field 0=hh,1=mm,2=ss, 4'hF = none
//   wr_req                     write request to the RTC
//   cursor_blink               cursor highlight gate
//   state_dbg        [1:0]     current FSM state (0 IDLE,1 LOAD,2 EDIT,3 COMMIT)
//
// Build option: define TIME_EDIT_BLINK_EN to make cursor_blink toggle every
// BLINK_DIV cycles while editing. Without it cursor_blink is constant 1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module time_edit_ctrl #(
    parameter int unsigned HOUR_MAX       = 23,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
    parameter logic [31:0] BLINK_DIV      = 32'd25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_prog,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic [7:0] rtc_hour,
    input  logic [7:0] rtc_min,
    input  logic [7:0] rtc_sec,
    input  logic       wr_ack,
    output logic [7:0] hour_out1,
    output logic [7:0] hour_out2,
    output logic [7:0] hour_out3,
    output logic       programar_on,
    output logic [3:0] direccion_actual_pantalla,
    output logic       wr_req,
    output logic       cursor_blink,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EDIT   = 2'd2,
        S_COMMIT = 2'd3
    } state_t;

    localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};
    localparam logic [7:0] MINSEC_MAX   = 8'h59;

    // Valid BCD values order the same way as their numeric values, so once
    // both nibbles are known to be digits a plain compare against max works.
    function automatic logic [7:0] bcd_sanitize(input logic [7:0] v, input logic [7:0] mx);
        logic [7:0] r;
        r = v;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > mx)) r = 8'h00;
        return r;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
        logic [7:0] r;
        if (v == mx)                r = 8'h00;
        else if (v[3:0] == 4'd9)    r = {v[7:4] + 4'd1, 4'd0};
        else                        r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
        logic [7:0] r;
        if (v == 8'h00)             r = mx;
        else if (v[3:0] == 4'd0)    r = {v[7:4] - 4'd1, 4'd9};
        else                        r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [2:0][7:0] edit_q, edit_d;        // [0]=hh, [1]=mm, [2]=ss
    logic [1:0]      cursor_q, cursor_d;
    logic [31:0]     tmo_q, tmo_d;
    logic [7:0]      field_max;
    logic            any_btn;

    logic [7:0]      hour_out1_q, hour_out1_d;
    logic [7:0]      hour_out2_q, hour_out2_d;
    logic [7:0]      hour_out3_q, hour_out3_d;
    logic            programar_on_q, programar_on_d;
    logic [3:0]      direccion_q, direccion_d;
    logic            wr_req_q, wr_req_d;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------ next-state / datapath
    always_comb begin
        state_d   = state_q;
        edit_d    = edit_q;
        cursor_d  = cursor_q;
        tmo_d     = tmo_q;
        any_btn   = btn_prog | btn_up | btn_down | btn_left | btn_right;
        field_max = (cursor_q == 2'd0) ? HOUR_MAX_BCD : MINSEC_MAX;

        case (state_q)
            S_IDLE: begin
                if (btn_prog) state_d = S_LOAD;
            end
            S_LOAD: begin
                edit_d[0] = bcd_sanitize(rtc_hour, HOUR_MAX_BCD);
                edit_d[1] = bcd_sanitize(rtc_min, MINSEC_MAX);
                edit_d[2] = bcd_sanitize(rtc_sec, MINSEC_MAX);
                cursor_d  = 2'd0;
                tmo_d     = '0;
                state_d   = S_EDIT;
            end
            S_EDIT: begin
                tmo_d = any_btn ? '0 : tmo_q + 32'd1;
                // One action per cycle; a button press always beats the timeout.
                if (btn_prog) begin
                    state_d = S_COMMIT;
                end else if (btn_right) begin
                    cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
                end else if (btn_left) begin
                    cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
                end else if (btn_up) begin
                    edit_d[cursor_q] = bcd_inc(edit_q[cursor_q], field_max);
                end else if (btn_down) begin
                    edit_d[cursor_q] = bcd_dec(edit_q[cursor_q], field_max);
                end else if (tmo_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d = S_IDLE;
                    tmo_d   = '0;
                end
            end
            S_COMMIT: begin
                if (wr_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Registered outputs are computed from the next state so that they line up
    // with state_q after the edge.
    always_comb begin
        hour_out1_d    = rtc_hour;
        hour_out2_d    = rtc_min;
        hour_out3_d    = rtc_sec;
        programar_on_d = 1'b0;
        direccion_d    = 4'hF;
        wr_req_d       = 1'b0;
        case (state_d)
            S_EDIT, S_COMMIT: begin
                hour_out1_d    = edit_d[0];
                hour_out2_d    = edit_d[1];
                hour_out3_d    = edit_d[2];
                programar_on_d = 1'b1;
                direccion_d    = {2'b00, cursor_d};
                wr_req_d       = (state_d == S_COMMIT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edit_q         <= '0;
            cursor_q       <= 2'd0;
            tmo_q          <= '0;
            hour_out1_q    <= 8'h00;
            hour_out2_q    <= 8'h00;
            hour_out3_q    <= 8'h00;
            programar_on_q <= 1'b0;
            direccion_q    <= 4'hF;
            wr_req_q       <= 1'b0;
        end else begin
            edit_q         <= edit_d;
            cursor_q       <= cursor_d;
            tmo_q          <= tmo_d;
            hour_out1_q    <= hour_out1_d;
            hour_out2_q    <= hour_out2_d;
            hour_out3_q    <= hour_out3_d;
            programar_on_q <= programar_on_d;
            direccion_q    <= direccion_d;
            wr_req_q       <= wr_req_d;
        end
    end

    assign hour_out1                 = hour_out1_q;
    assign hour_out2                 = hour_out2_q;
    assign hour_out3                 = hour_out3_q;
    assign programar_on              = programar_on_q;
    assign direccion_actual_pantalla = direccion_q;
    assign wr_req                    = wr_req_q;
    assign state_dbg                 = state_q;

    // ---------------------------------------------------------------- blink
`ifdef TIME_EDIT_BLINK_EN
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic        blink_q, blink_d;
    logic        edit_act;

    always_comb begin
        // Cursor moves and value edits restart the blink phase so the user
        // always sees the highlight right after acting.
        edit_act    = (state_q == S_EDIT) && !btn_prog &&
                      (btn_right | btn_left | btn_up | btn_down);
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_d     = blink_q;
        if ((state_q != S_EDIT) || (state_d != S_EDIT) || edit_act) begin
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (blink_cnt_q == BLINK_DIV - 32'd1) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign cursor_blink = blink_q;
`else
    // BLINK_DIV has no effect in this build; it is referenced so both builds
    // share one parameter list. The expression is always 1.
    assign cursor_blink = 1'b1 | ~|BLINK_DIV;
`endif

endmodule

// File: tb/tb_time_edit_ctrl.sv
`timescale 1ns/1ps

module tb_time_edit_ctrl;

    localparam int HMAX = 23;
    localparam int TMO  = 100;
    localparam int W    = 30;   // {h1,h2,h3,prog,dir,wr}

    // ------------------------------------------------------------ clock/reset
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_prog = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, wr_ack = 1'b0;
    logic [7:0] rtc_hour = 8'h00, rtc_min = 8'h00, rtc_sec = 8'h00;
    logic [7:0] hour_out1, hour_out2, hour_out3;
    logic       programar_on, wr_req, cursor_blink;
    logic [3:0] direccion_actual_pantalla;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    time_edit_ctrl #(
        .HOUR_MAX(HMAX),
        .TIMEOUT_CYCLES(32'(TMO)),
        .BLINK_DIV(32'd8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_prog(btn_prog),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .btn_left(btn_left),
        .btn_right(btn_right),
        .rtc_hour(rtc_hour),
        .rtc_min(rtc_min),
        .rtc_sec(rtc_sec),
        .wr_ack(wr_ack),
        .hour_out1(hour_out1),
        .hour_out2(hour_out2),
        .hour_out3(hour_out3),
        .programar_on(programar_on),
        .direccion_actual_pantalla(direccion_actual_pantalla),
        .wr_req(wr_req),
        .cursor_blink(cursor_blink),
        .state_dbg(state_dbg)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------ reference model
    // Fields are held as plain binary numbers; edits are modular arithmetic.
    localparam int M_IDLE = 0, M_LOAD = 1, M_EDIT = 2, M_COMMIT = 3;
    int         m_mode, m_cur, m_quiet;
    int         m_val[3];
    logic [7:0] e_h1, e_h2, e_h3;
    logic       e_prog, e_wr;
    logic [3:0] e_dir;
    logic [W-1:0] exp_q[$];

    function automatic int lim(input int idx);
        return (idx == 0) ? HMAX : 59;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    function automatic int legal(input logic [7:0] b, input int mx);
        int t = int'(b[7:4]);
        int u = int'(b[3:0]);
        if (t > 9 || u > 9) return 0;
        if (t * 10 + u > mx) return 0;
        return t * 10 + u;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_cur = 0; m_quiet = 0;
        m_val[0] = 0; m_val[1] = 0; m_val[2] = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic p, u, d, l, r, a);
        logic any_b;
        any_b = p | u | d | l | r;
        case (m_mode)
            M_IDLE: if (p) m_mode = M_LOAD;
            M_LOAD: begin
                m_val[0] = legal(rtc_hour, HMAX);
                m_val[1] = legal(rtc_min, 59);
                m_val[2] = legal(rtc_sec, 59);
                m_cur = 0; m_quiet = 0; m_mode = M_EDIT;
            end
            M_EDIT: begin
                if (p)      m_mode = M_COMMIT;
                else if (r) m_cur = (m_cur + 1) % 3;
                else if (l) m_cur = (m_cur + 2) % 3;
                else if (u) m_val[m_cur] = (m_val[m_cur] + 1) % (lim(m_cur) + 1);
                else if (d) m_val[m_cur] = (m_val[m_cur] + lim(m_cur)) % (lim(m_cur) + 1);
                else if (m_quiet == TMO - 1) m_mode = M_IDLE;
                m_quiet = any_b ? 0 : m_quiet + 1;
            end
            default: if (a) m_mode = M_IDLE;
        endcase
        if (m_mode == M_EDIT || m_mode == M_COMMIT) begin
            e_h1 = to_bcd(m_val[0]); e_h2 = to_bcd(m_val[1]); e_h3 = to_bcd(m_val[2]);
            e_prog = 1'b1; e_dir = 4'(m_cur); e_wr = (m_mode == M_COMMIT);
        end else begin
            e_h1 = rtc_hour; e_h2 = rtc_min; e_h3 = rtc_sec;
            e_prog = 1'b0; e_dir = 4'hF; e_wr = 1'b0;
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    task automatic check_model(input string name);
        logic [W-1:0] exp_v, act_v;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        exp_v = exp_q.pop_front();
        act_v = {hour_out1, hour_out2, hour_out3, programar_on, direccion_actual_pantalla, wr_req};
        if (act_v !== exp_v || cursor_blink !== 1'b1) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h:%h:%h prog=%b dir=%h wr=%b blink=%b, want %h:%h:%h prog=%b dir=%h wr=%b blink=1",
                     name, $time, act_v[29:22], act_v[21:14], act_v[13:6], act_v[5], act_v[4:1], act_v[0],
                     cursor_blink, exp_v[29:22], exp_v[21:14], exp_v[13:6], exp_v[5], exp_v[4:1], exp_v[0]);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp_v);
        end
    endtask

    // ------------------------------------------------------------ driver
    task automatic cycle(input logic p, u, d, l, r, a, input string name);
        btn_prog = p; btn_up = u; btn_down = d; btn_left = l; btn_right = r; wr_ack = a;
        model_step(p, u, d, l, r, a);
        exp_q.push_back({e_h1, e_h2, e_h3, e_prog, e_dir, e_wr});
        @(posedge clk); #1;
        btn_prog = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; wr_ack = 0;
        check_model(name);
    endtask

    task automatic idle_cyc(input string name);
        cycle(0, 0, 0, 0, 0, 0, name);
    endtask

    task automatic set_rtc(input logic [7:0] h, m, s);
        rtc_hour = h; rtc_min = m; rtc_sec = s;
    endtask

    function automatic logic [7:0] rand_field(input int mx);
        if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
        return to_bcd(int'($urandom_range(0, mx)));
    endfunction

    // ------------------------------------------------------------ vector table
    typedef struct {
        logic       p, u, d, l, r, a;
        logic [7:0] eh, em, es;
        logic       ep;
        logic [3:0] ed;
        logic       ew;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int n;
        logic saw_wr;

        // rtc held at 23:59:09 for the table
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h23,8'h59,8'h09, 1'b0,4'hF,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h23,8'h59,8'h09, 1'b0,4'hF,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 8'h23,8'h59,8'h09, 1'b1,4'h0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h00,8'h59,8'h09, 1'b1,4'h0,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 8'h23,8'h59,8'h09, 1'b1,4'h0,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 8'h22,8'h59,8'h09, 1'b1,4'h0,1'b0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h22,8'h59,8'h09, 1'b1,4'h1,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h22,8'h59,8'h09, 1'b1,4'h2,1'b0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 8'h22,8'h59,8'h09, 1'b1,4'h0,1'b0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'h22,8'h59,8'h09, 1'b1,4'h2,1'b0};
        tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h22,8'h59,8'h10, 1'b1,4'h2,1'b0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 8'h22,8'h59,8'h10, 1'b1,4'h1,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h22,8'h00,8'h10, 1'b1,4'h1,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 8'h22,8'h59,8'h10, 1'b1,4'h1,1'b0};
        tbl[14] = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 8'h22,8'h00,8'h10, 1'b1,4'h1,1'b0};
        tbl[15] = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 8'h22,8'h00,8'h10, 1'b1,4'h0,1'b0};
        tbl[16] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h22,8'h00,8'h10, 1'b1,4'h0,1'b1};
        tbl[17] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 8'h22,8'h00,8'h10, 1'b1,4'h0,1'b1};
        tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 8'h23,8'h59,8'h09, 1'b0,4'hF,1'b0};
        tbl[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 8'h23,8'h59,8'h09, 1'b0,4'hF,1'b0};

        // ---- reset state and first IDLE sample
        model_reset();
        set_rtc(8'h12, 8'h34, 8'h56);
        #12;
        chk("rst_h1", int'(hour_out1), 8'h00);
        chk("rst_prog_dir_wr", int'({programar_on, direccion_actual_pantalla, wr_req}), 6'b0_1111_0);
        chk("rst_blink", int'(cursor_blink), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cyc("idle_follow");
        chk("idle_h", int'({hour_out1, hour_out2, hour_out3}), 24'h123456);

        // ---- table
        set_rtc(8'h23, 8'h59, 8'h09);
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].p, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].a, "tbl_model");
            n_tests++;
            if ({hour_out1, hour_out2, hour_out3, programar_on, direccion_actual_pantalla, wr_req} !==
                {tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].ep, tbl[i].ed, tbl[i].ew}) begin
                n_fail++;
                $display("FAIL tbl[%0d]: got %h:%h:%h prog=%b dir=%h wr=%b, want %h:%h:%h prog=%b dir=%h wr=%b",
                         i, hour_out1, hour_out2, hour_out3, programar_on, direccion_actual_pantalla, wr_req,
                         tbl[i].eh, tbl[i].em, tbl[i].es, tbl[i].ep, tbl[i].ed, tbl[i].ew);
            end
        end
        chk("state_idle_after_ack", int'(state_dbg), 0);

        // ---- edit to 07:45:00, ss wrap both ways, held handshake
        set_rtc(8'h06, 8'h45, 8'h59);
        cycle(1, 0, 0, 0, 0, 0, "c4_prog");
        idle_cyc("c4_load");
        cycle(0, 1, 0, 0, 0, 0, "c4_up_hh");
        chk("c4_hh07", int'(hour_out1), 8'h07);
        cycle(0, 0, 0, 1, 0, 0, "c4_left");
        chk("c4_dir2", int'(direccion_actual_pantalla), 2);
        cycle(0, 1, 0, 0, 0, 0, "c4_ss_up");
        chk("c4_ss59_to_00", int'(hour_out3), 8'h00);
        cycle(0, 0, 1, 0, 0, 0, "c4_ss_down");
        chk("c4_ss00_to_59", int'(hour_out3), 8'h59);
        cycle(0, 1, 0, 0, 0, 0, "c4_ss_up2");
        cycle(1, 0, 0, 0, 0, 0, "c4_commit");
        chk("c4_commit_bus", int'({hour_out1, hour_out2, hour_out3, wr_req}), {24'h074500, 1'b1});
        for (int i = 0; i < 10; i++) begin
            idle_cyc("c4_hold");
            chk("c4_wr_held", int'({wr_req, hour_out1, hour_out2, hour_out3}), {1'b1, 24'h074500});
        end
        set_rtc(8'h11, 8'h22, 8'h33);
        cycle(0, 0, 0, 0, 0, 1, "c4_ack");
        chk("c4_after_ack", int'({wr_req, programar_on, hour_out1, hour_out2, hour_out3}), {2'b00, 24'h112233});

        // ---- timeout with no buttons
        set_rtc(8'h10, 8'h20, 8'h30);
        cycle(1, 0, 0, 0, 0, 0, "c5_prog");
        idle_cyc("c5_load");
        n = 0; saw_wr = 1'b0;
        while (programar_on === 1'b1 && n < 200) begin
            idle_cyc("c5_quiet");
            saw_wr |= wr_req;
            n++;
        end
        chk("c5_timeout_len", n, TMO);
        chk("c5_no_write", int'(saw_wr), 0);

        // ---- timeout restarted by a press at cycle 50; LOAD ignores buttons
        cycle(1, 0, 0, 0, 0, 0, "c5b_prog");
        cycle(0, 1, 0, 0, 0, 0, "c5b_load_up");
        chk("c5b_load_ignores_up", int'(hour_out1), 8'h10);
        for (int i = 0; i < 50; i++) idle_cyc("c5b_quiet");
        chk("c5b_still_edit", int'(programar_on), 1);
        cycle(0, 1, 0, 0, 0, 0, "c5b_up");
        n = 0; saw_wr = 1'b0;
        while (programar_on === 1'b1 && n < 200) begin
            idle_cyc("c5b_quiet2");
            saw_wr |= wr_req;
            n++;
        end
        chk("c5b_timeout_len", n, TMO);
        chk("c5b_no_write", int'(saw_wr), 0);

        // ---- illegal snapshot, up+down, reset during COMMIT
        set_rtc(8'h12, 8'h7A, 8'h30);
        cycle(1, 0, 0, 0, 0, 0, "c6_prog");
        idle_cyc("c6_load");
        chk("c6_min_forced_00", int'({hour_out1, hour_out2, hour_out3}), 24'h120030);
        cycle(0, 0, 0, 0, 1, 0, "c6_right");
        cycle(0, 1, 1, 0, 0, 0, "c6_updown");
        chk("c6_up_wins", int'(hour_out2), 8'h01);
        cycle(1, 0, 0, 0, 0, 0, "c6_commit");
        chk("c6_wr_req", int'(wr_req), 1);
        reset = 1'b0;
        #2;
        chk("c6_async_rst", int'({wr_req, programar_on, direccion_actual_pantalla, hour_out2}), {2'b00, 4'hF, 8'h00});
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;

        // ---- randomized traffic against the model
        for (int blk = 0; blk < 6; blk++) begin
            int dens;
            logic p, u, d, l, r, a;
            dens = (blk % 3 == 0) ? 3 : (blk % 3 == 1) ? 15 : 400;
            for (int c = 0; c < 300; c++) begin
                rtc_hour = rand_field(HMAX);
                rtc_min  = rand_field(59);
                rtc_sec  = rand_field(59);
                p = ($urandom_range(0, dens * 2) == 0);
                u = ($urandom_range(0, dens) == 0);
                d = ($urandom_range(0, dens) == 0);
                l = ($urandom_range(0, dens) == 0);
                r = ($urandom_range(0, dens) == 0);
                a = ($urandom_range(0, 3) == 0);
                cycle(p, u, d, l, r, a, "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
